// File: rtl/branch_pkg.sv
// Shared types for the flag/branch path: branch kinds, condition codes,
// NZCV bit positions and the redirect FSM state encoding.
package branch_pkg;

    typedef enum logic [1:0] {
        BR_NONE  = 2'd0,
        BR_B     = 2'd1,
        BR_CBZ   = 2'd2,
        BR_BCOND = 2'd3
    } br_type_e;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1,
        COND_HS = 4'h2, COND_LO = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5,
        COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9,
        COND_GE = 4'hA, COND_LT = 4'hB,
        COND_GT = 4'hC, COND_LE = 4'hD,
        COND_AL = 4'hE, COND_NV = 4'hF
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } state_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code evaluator: {NZCV, cond} -> pass.
// Kept standalone so a conditional-select datapath can reuse it.
import branch_pkg::*;

module cond_eval (
    input  logic [3:0] flags,
    input  cond_e      cond,
    output logic       pass
);

    logic n;
    logic z;
    logic c;
    logic v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    // Decode the 16 condition codes against the supplied flags.
    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_HS: pass = c;
            COND_LO: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~(c & ~z);
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = ~(~z & (n == v));
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_branch_unit.sv
// NZCV flag register plus EX-stage branch resolution with a registered
// redirect and a one-cycle wrong-path squash after every taken branch.
// Optional feature macro: BRANCH_STATS_EN adds saturating taken/not-taken
// counters and their output ports.
import branch_pkg::*;

module flag_branch_unit #(
    parameter int ADDR_W = 64,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic              ex_set_flags,
    input  logic [3:0]        ex_flags,
    input  logic              br_valid,
    input  logic [1:0]        br_type,
    input  logic [3:0]        br_cond,
    input  logic              cbz_zero,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [ADDR_W-1:0] br_offset,
    output logic              take_branch,
    output logic [ADDR_W-1:0] target_pc,
    output logic              flush,
    output logic [3:0]        flags_q
`ifdef BRANCH_STATS_EN
    ,
    output logic [CNT_W-1:0]  taken_cnt,
    output logic [CNT_W-1:0]  nottaken_cnt
`endif
);

    // Reject parameterisations that cannot hold a word-aligned target or a count.
    if (ADDR_W < 3 || CNT_W < 1) begin : g_bad_params
        $error("flag_branch_unit: ADDR_W must be >= 3 and CNT_W >= 1");
    end

    state_e            state_reg;
    logic [3:0]        flags_reg;
    logic              take_reg;
    logic [ADDR_W-1:0] target_reg;

    logic              squashed;
    logic              flag_wr;
    logic [3:0]        eff_flags;
    logic              br_live;
    logic              cond_pass;
    logic              taken_next;
    logic [ADDR_W-1:0] target_next;

    // The cycle after a taken redirect carries wrong-path inputs.
    assign squashed    = (state_reg == ST_SQUASH);
    assign flag_wr     = ex_valid & ex_set_flags & ~squashed;
    // Same-cycle flag producer forwards straight into the condition check.
    assign eff_flags   = (ex_valid & ex_set_flags) ? ex_flags : flags_reg;
    assign br_live     = br_valid & ~squashed;
    assign target_next = br_pc + (br_offset << 2);

    cond_eval u_cond_eval (
        .flags (eff_flags),
        .cond  (cond_e'(br_cond)),
        .pass  (cond_pass)
    );

    // Taken decision for the live branch in EX.
    always_comb begin
        taken_next = 1'b0;
        if (br_live) begin
            case (br_type_e'(br_type))
                BR_B:     taken_next = 1'b1;
                BR_CBZ:   taken_next = cbz_zero;
                BR_BCOND: taken_next = cond_pass;
                default:  taken_next = 1'b0;
            endcase
        end
    end

    // Flag register, registered redirect outputs and the squash FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_RUN;
            flags_reg  <= 4'b0000;
            take_reg   <= 1'b0;
            target_reg <= '0;
        end else begin
            if (flag_wr) begin
                flags_reg <= ex_flags;
            end
            take_reg <= taken_next;
            if (taken_next) begin
                target_reg <= target_next;
            end
            case (state_reg)
                ST_RUN:    state_reg <= taken_next ? ST_SQUASH : ST_RUN;
                ST_SQUASH: state_reg <= ST_RUN;
                default:   state_reg <= ST_RUN;
            endcase
        end
    end

    assign take_branch = take_reg;
    assign flush       = take_reg;
    assign target_pc   = target_reg;
    assign flags_q     = flags_reg;

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] taken_cnt_reg;
    logic [CNT_W-1:0] nottaken_cnt_reg;
    logic             counted;

    assign counted = br_live & (br_type != BR_NONE);

    // Saturating per-outcome branch counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            taken_cnt_reg    <= '0;
            nottaken_cnt_reg <= '0;
        end else if (counted) begin
            if (taken_next) begin
                if (taken_cnt_reg != {CNT_W{1'b1}}) begin
                    taken_cnt_reg <= taken_cnt_reg + 1'b1;
                end
            end else begin
                if (nottaken_cnt_reg != {CNT_W{1'b1}}) begin
                    nottaken_cnt_reg <= nottaken_cnt_reg + 1'b1;
                end
            end
        end
    end

    assign taken_cnt    = taken_cnt_reg;
    assign nottaken_cnt = nottaken_cnt_reg;
`endif

endmodule

// File: tb/tb_flag_branch_unit.sv
// Self-checking bench for flag_branch_unit: directed scenarios pinned with
// literal expectations, then randomized traffic against a behavioural model.
// Build with BRANCH_STATS_EN defined to also check the branch counters.
module tb_flag_branch_unit;

    localparam int ADDR_W = 64;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              ex_valid;
    logic              ex_set_flags;
    logic [3:0]        ex_flags;
    logic              br_valid;
    logic [1:0]        br_type;
    logic [3:0]        br_cond;
    logic              cbz_zero;
    logic [ADDR_W-1:0] br_pc;
    logic [ADDR_W-1:0] br_offset;
    logic              take_branch;
    logic [ADDR_W-1:0] target_pc;
    logic              flush;
    logic [3:0]        flags_q;
`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0]  taken_cnt;
    logic [CNT_W-1:0]  nottaken_cnt;
`endif

    flag_branch_unit #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .ex_valid     (ex_valid),
        .ex_set_flags (ex_set_flags),
        .ex_flags     (ex_flags),
        .br_valid     (br_valid),
        .br_type      (br_type),
        .br_cond      (br_cond),
        .cbz_zero     (cbz_zero),
        .br_pc        (br_pc),
        .br_offset    (br_offset),
        .take_branch  (take_branch),
        .target_pc    (target_pc),
        .flush        (flush),
        .flags_q      (flags_q)
`ifdef BRANCH_STATS_EN
        ,
        .taken_cnt    (taken_cnt),
        .nottaken_cnt (nottaken_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model state: what the outputs must read after the edge.
    logic [3:0]        m_flags;
    bit                m_take;
    logic [ADDR_W-1:0] m_target;
    logic [CNT_W-1:0]  m_tc;
    logic [CNT_W-1:0]  m_nc;

    // Architectural condition test: even codes test a base predicate,
    // odd codes its negation; the last pair is unconditional.
    function automatic bit m_cond(input logic [3:0] f, input logic [3:0] code);
        bit n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (code / 2)
            0: base = z;
            1: base = c;
            2: base = n;
            3: base = v;
            4: base = c && !z;
            5: base = (n == v);
            6: base = !z && (n == v);
            default: return 1'b1;
        endcase
        return (code % 2 == 1) ? !base : base;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input bit ev, input bit sf, input logic [3:0] fl,
                          input bit bv, input logic [1:0] bt, input logic [3:0] bc,
                          input bit cz, input logic [63:0] pc, input logic [63:0] off);
        ex_valid = ev; ex_set_flags = sf; ex_flags = fl;
        br_valid = bv; br_type = bt; br_cond = bc; cbz_zero = cz;
        br_pc = pc; br_offset = off;
    endtask

    task automatic idle();
        set_in(0, 0, 4'b0000, 0, 2'd0, 4'h0, 0, 64'h0, 64'h0);
    endtask

    // Advance one clock: fold the current inputs into the model, then
    // compare every output against it shortly after the edge.
    task automatic cycle();
        bit         wrong_path;
        bit         tk;
        logic [3:0] ef;
        if (reset) begin
            m_flags = 4'b0000; m_take = 0; m_target = '0; m_tc = '0; m_nc = '0;
        end else begin
            wrong_path = m_take;
            ef = (ex_valid && ex_set_flags) ? ex_flags : m_flags;
            tk = 0;
            if (br_valid && !wrong_path) begin
                if (br_type == 2'd1)      tk = 1;
                else if (br_type == 2'd2) tk = cbz_zero;
                else if (br_type == 2'd3) tk = m_cond(ef, br_cond);
                if (br_type != 2'd0) begin
                    if (tk && m_tc != {CNT_W{1'b1}})  m_tc = m_tc + 1;
                    if (!tk && m_nc != {CNT_W{1'b1}}) m_nc = m_nc + 1;
                end
            end
            if (ex_valid && ex_set_flags && !wrong_path) m_flags = ex_flags;
            if (tk) m_target = br_pc + br_offset * 4;
            m_take = tk;
        end
        @(posedge clk);
        #1;
        check("take_branch", 64'(take_branch), 64'(m_take));
        check("flush", 64'(flush), 64'(m_take));
        check("target_pc", target_pc, m_target);
        check("flags_q", 64'(flags_q), 64'(m_flags));
`ifdef BRANCH_STATS_EN
        check("taken_cnt", 64'(taken_cnt), 64'(m_tc));
        check("nottaken_cnt", 64'(nottaken_cnt), 64'(m_nc));
`endif
    endtask

    task automatic show(input string tag);
        $display("txn %s: take=%0d flush=%0d target=%0h flags=%b", tag, take_branch, flush, target_pc, flags_q);
    endtask

    initial begin
        idle();
        reset = 1;
        cycle();
        cycle();
        show("reset");
        check("rst_take", 64'(take_branch), 64'd0);
        check("rst_flush", 64'(flush), 64'd0);
        check("rst_target", target_pc, 64'd0);
        check("rst_flags", 64'(flags_q), 64'd0);
        reset = 0;

        // SUBS writes Z, then B.EQ one cycle later.
        set_in(1, 1, 4'b0100, 0, 2'd0, 4'h0, 0, 64'h0, 64'h0);
        cycle();
        set_in(1, 0, 4'b0000, 1, 2'd3, 4'h0, 0, 64'h100, 64'd3);
        cycle();
        show("beq");
        check("beq_take", 64'(take_branch), 64'd1);
        check("beq_flush", 64'(flush), 64'd1);
        check("beq_target", target_pc, 64'h10C);
        check("beq_flags", 64'(flags_q), 64'b0100);
        idle();
        cycle();
        check("beq_oneshot", 64'(take_branch), 64'd0);

        // Forwarded flags into B.LT.
        set_in(1, 1, 4'b0000, 0, 2'd0, 4'h0, 0, 64'h0, 64'h0);
        cycle();
        set_in(1, 1, 4'b1000, 1, 2'd3, 4'hB, 0, 64'h300, 64'd1);
        cycle();
        show("blt_fwd_taken");
        check("blt_fwd_take", 64'(take_branch), 64'd1);
        check("blt_fwd_target", target_pc, 64'h304);
        idle();
        cycle();
        set_in(1, 1, 4'b0000, 0, 2'd0, 4'h0, 0, 64'h0, 64'h0);
        cycle();
        set_in(1, 1, 4'b1001, 1, 2'd3, 4'hB, 0, 64'h400, 64'd1);
        cycle();
        show("blt_fwd_not");
        check("blt_fwd_nottake", 64'(take_branch), 64'd0);
        check("blt_fwd_flags", 64'(flags_q), 64'b1001);

        // CBZ not taken must not open a squash window.
        set_in(0, 0, 4'b0000, 1, 2'd2, 4'h0, 0, 64'h500, 64'd5);
        cycle();
        show("cbz_not");
        check("cbz_not_take", 64'(take_branch), 64'd0);
        set_in(0, 0, 4'b0000, 1, 2'd2, 4'h0, 1, 64'h200, 64'hFFFF_FFFF_FFFF_FFFE);
        cycle();
        show("cbz_taken");
        check("cbz_take", 64'(take_branch), 64'd1);
        check("cbz_target", target_pc, 64'h1F8);
        idle();
        cycle();

        // Wrong-path B plus flag write after a taken B are both dropped.
        set_in(0, 0, 4'b0000, 1, 2'd1, 4'h0, 0, 64'h40, 64'd4);
        cycle();
        show("b_0x40");
        check("b40_target", target_pc, 64'h50);
        set_in(1, 1, 4'b1111, 1, 2'd1, 4'h0, 0, 64'h80, 64'd8);
        cycle();
        show("squashed");
        check("sq_take", 64'(take_branch), 64'd0);
        check("sq_flags", 64'(flags_q), 64'b1001);
        check("sq_target_hold", target_pc, 64'h50);

        // Target wraps silently.
        set_in(0, 0, 4'b0000, 1, 2'd1, 4'h0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd1);
        cycle();
        show("wrap");
        check("wrap_take", 64'(take_branch), 64'd1);
        check("wrap_target", target_pc, 64'h0);

        // Reset during the squash cycle clears everything.
        set_in(1, 1, 4'b1111, 1, 2'd1, 4'h0, 0, 64'h900, 64'd1);
        reset = 1;
        cycle();
        show("reset_in_squash");
        check("rsq_take", 64'(take_branch), 64'd0);
        check("rsq_flush", 64'(flush), 64'd0);
        check("rsq_flags", 64'(flags_q), 64'd0);
`ifdef BRANCH_STATS_EN
        check("rsq_tcnt", 64'(taken_cnt), 64'd0);
        check("rsq_ncnt", 64'(nottaken_cnt), 64'd0);
`endif
        reset = 0;

        // 3 taken, 2 not taken, one NONE that must not count.
        set_in(0, 0, 4'b0000, 1, 2'd1, 4'h0, 0, 64'h10, 64'd1); cycle();
        idle(); cycle();
        set_in(0, 0, 4'b0000, 1, 2'd2, 4'h0, 1, 64'h20, 64'd1); cycle();
        idle(); cycle();
        set_in(0, 0, 4'b0000, 1, 2'd3, 4'hE, 0, 64'h30, 64'd1); cycle();
        idle(); cycle();
        set_in(0, 0, 4'b0000, 1, 2'd2, 4'h0, 0, 64'h40, 64'd1); cycle();
        set_in(0, 0, 4'b0000, 1, 2'd3, 4'h0, 0, 64'h50, 64'd1); cycle();
        set_in(0, 0, 4'b0000, 1, 2'd0, 4'h0, 0, 64'h60, 64'd1); cycle();
        show("stats");
        check("stats_take", 64'(take_branch), 64'd0);
`ifdef BRANCH_STATS_EN
        check("stats_tcnt", 64'(taken_cnt), 64'd3);
        check("stats_ncnt", 64'(nottaken_cnt), 64'd2);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            reset        = ($urandom_range(0, 249) == 0);
            ex_valid     = $urandom_range(0, 1);
            ex_set_flags = $urandom_range(0, 1);
            ex_flags     = 4'($urandom);
            br_valid     = ($urandom_range(0, 2) != 0);
            br_type      = 2'($urandom);
            br_cond      = 4'($urandom);
            cbz_zero     = $urandom_range(0, 1);
            br_pc        = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) br_offset = {$urandom, $urandom};
            else                           br_offset = 64'($signed($urandom_range(0, 2000)) - 1000);
            cycle();
        end
        reset = 0;
        idle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
